// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle integer divider and its EX-stage user:
// bus widths, handshake levels, ALU opcodes, FSM states and sign helpers.
package div_pkg;

  localparam int REG_BUS        = 32;
  localparam int DOUBLE_REG_BUS = 64;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  // Two's-complement negation of a register-width value.
  function automatic logic [REG_BUS-1:0] twos_neg(input logic [REG_BUS-1:0] v);
    return (~v) + 32'd1;
  endfunction

  // Magnitude of an operand: negative values are negated only in signed mode.
  function automatic logic [REG_BUS-1:0] op_mag(input logic sgn_mode,
                                                input logic [REG_BUS-1:0] v);
    logic [REG_BUS-1:0] m;
    if (sgn_mode && v[REG_BUS-1]) begin
      m = twos_neg(v);
    end else begin
      m = v;
    end
    return m;
  endfunction

endpackage

// File: rtl/div.sv
// Restoring 32-bit divider, one quotient bit per clock. Produces
// {remainder, quotient} for the HI/LO write; operands are latched on
// acceptance so EX may change them freely while the division runs.
module div
  import div_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      signed_div_i,
  input  logic [REG_BUS-1:0]        opdata1_i,
  input  logic [REG_BUS-1:0]        opdata2_i,
  input  logic                      start_i,
  input  logic                      annul_i,
  output logic [DOUBLE_REG_BUS-1:0] result_o,
  output logic                      ready_o
);

  div_state_e                r_state;
  logic [5:0]                r_cnt;
  logic [64:0]               r_dividend;
  logic [REG_BUS-1:0]        r_divisor;
  logic                      r_sign_q;
  logic                      r_sign_r;
  logic                      r_ready;
  logic [DOUBLE_REG_BUS-1:0] r_result;

  div_state_e                w_state_nxt;
  logic [5:0]                w_cnt_nxt;
  logic [64:0]               w_dividend_nxt;
  logic [REG_BUS-1:0]        w_divisor_nxt;
  logic                      w_sign_q_nxt;
  logic                      w_sign_r_nxt;
  logic                      w_ready_nxt;
  logic [DOUBLE_REG_BUS-1:0] w_result_nxt;

  logic [32:0]               w_diff;
  logic [REG_BUS-1:0]        w_quo;
  logic [REG_BUS-1:0]        w_rem;

  // Trial subtraction of the divisor from the current partial remainder;
  // bit 32 set means the divisor did not fit.
  assign w_diff = {1'b0, r_dividend[63:32]} - {1'b0, r_divisor};

  // Sign-corrected results once all 32 steps are done.
  assign w_quo = r_sign_q ? twos_neg(r_dividend[31:0])  : r_dividend[31:0];
  assign w_rem = r_sign_r ? twos_neg(r_dividend[64:33]) : r_dividend[64:33];

  assign ready_o  = r_ready;
  assign result_o = r_result;

  // Register all divider state; reset aborts any division in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= DIV_FREE;
      r_cnt      <= 6'd0;
      r_dividend <= 65'd0;
      r_divisor  <= 32'd0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_ready    <= DIV_RESULT_NOT_READY;
      r_result   <= 64'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_dividend <= w_dividend_nxt;
      r_divisor  <= w_divisor_nxt;
      r_sign_q   <= w_sign_q_nxt;
      r_sign_r   <= w_sign_r_nxt;
      r_ready    <= w_ready_nxt;
      r_result   <= w_result_nxt;
    end
  end

  // Next-state and datapath update; annul wins over start everywhere.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_dividend_nxt = r_dividend;
    w_divisor_nxt  = r_divisor;
    w_sign_q_nxt   = r_sign_q;
    w_sign_r_nxt   = r_sign_r;
    w_ready_nxt    = r_ready;
    w_result_nxt   = r_result;

    case (r_state)
      DIV_FREE: begin
        w_ready_nxt  = DIV_RESULT_NOT_READY;
        w_result_nxt = 64'd0;
        if ((start_i == DIV_START) && !annul_i) begin
          w_sign_q_nxt   = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
          w_sign_r_nxt   = signed_div_i & opdata1_i[31];
          w_divisor_nxt  = op_mag(signed_div_i, opdata2_i);
          w_dividend_nxt = {32'd0, op_mag(signed_div_i, opdata1_i), 1'b0};
          w_cnt_nxt      = 6'd0;
          if (opdata2_i == 32'd0) begin
            w_state_nxt = DIV_BY_ZERO;
          end else begin
            w_state_nxt = DIV_ON;
          end
        end else begin
          w_state_nxt = DIV_FREE;
        end
      end

      DIV_BY_ZERO: begin
        if (annul_i) begin
          w_state_nxt  = DIV_FREE;
          w_ready_nxt  = DIV_RESULT_NOT_READY;
          w_result_nxt = 64'd0;
        end else begin
          w_state_nxt  = DIV_END;
          w_ready_nxt  = DIV_RESULT_READY;
          w_result_nxt = 64'd0;
        end
      end

      DIV_ON: begin
        if (annul_i) begin
          w_state_nxt  = DIV_FREE;
          w_cnt_nxt    = 6'd0;
          w_ready_nxt  = DIV_RESULT_NOT_READY;
          w_result_nxt = 64'd0;
        end else if (r_cnt == 6'd32) begin
          w_state_nxt  = DIV_END;
          w_cnt_nxt    = 6'd0;
          w_ready_nxt  = DIV_RESULT_READY;
          w_result_nxt = {w_rem, w_quo};
        end else begin
          w_cnt_nxt = r_cnt + 6'd1;
          if (w_diff[32]) begin
            w_dividend_nxt = {r_dividend[63:0], 1'b0};
          end else begin
            w_dividend_nxt = {w_diff[31:0], r_dividend[31:0], 1'b1};
          end
        end
      end

      DIV_END: begin
        if (annul_i || (start_i == DIV_STOP)) begin
          w_state_nxt  = DIV_FREE;
          w_ready_nxt  = DIV_RESULT_NOT_READY;
          w_result_nxt = 64'd0;
        end else begin
          w_state_nxt  = DIV_END;
          w_ready_nxt  = DIV_RESULT_READY;
        end
      end

      default: begin
        w_state_nxt    = DIV_FREE;
        w_cnt_nxt      = 6'd0;
        w_dividend_nxt = 65'd0;
        w_ready_nxt    = DIV_RESULT_NOT_READY;
        w_result_nxt   = 64'd0;
      end
    endcase
  end

endmodule

// File: doc/div.md
# div

Multi-cycle 32-bit integer divider serving the EX stage for DIV/DIVU. EX raises `start_i` with both operands and stalls the pipeline until `ready_o`. It then forwards the 64-bit result as the HI/LO write request, with remainder to HI and quotient to LO. The divider uses one restoring-division step per clock and holds its own state, so EX stays purely combinational.

## Interface
Parameters:
- none; widths come from the shared defines (`RegBus` = 32, `DoubleRegBus` = 64).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- `opdata1_i`  in  32  dividend.
- `opdata2_i`  in  32  divisor.
- `start_i`  in  1  request; held high by EX until `ready_o` is seen.
- `annul_i`  in  1  cancel the current or pending division (branch flush or exception).
- `result_o`  out  64  {remainder, quotient}, i.e. {HI, LO}.
- `ready_o`  out  1  result valid.

## Operation
States (2-bit): DivFree, DivByZero, DivOn, DivEnd.

DivFree:
- `start_i`=1 and `annul_i`=0 → accept the request and latch the operands.
- If `opdata2_i`=0 → go to DivByZero.
- Otherwise → go to DivOn with `cnt`=0.
- Signed mode: take the two's-complement magnitude of each negative operand; record `sign_q` = opdata1[31]^opdata2[31] and `sign_r` = opdata1[31].
- Load the 65-bit working register `dividend` = {32'b0, |op1|, 1'b0}.

DivByZero:
- Next state is DivEnd with `result_o`=0.

DivOn:
- Each step: `minuend` = `dividend[63:32]`; compute the 33-bit `diff` = {1'b0, minuend} − {1'b0, |op2|}.
- If `diff[32]`=1 → `dividend` = `dividend` << 1.
- Else → `dividend` = {`diff[31:0]`, `dividend[31:0]`, 1'b1} << 0, i.e. the quotient bit shifts in as 1.
- Increment `cnt` after each step.
- When `cnt`=32: finalize, then go to DivEnd.
  - Quotient = `dividend[31:0]`, negated if `sign_q`.
  - Remainder = `dividend[64:33]`, negated if `sign_r`.
- `annul_i`=1 in any DivOn cycle → DivFree; result discarded and `ready_o` stays 0.

DivEnd:
- `ready_o`=1 and `result_o` is held stable while `start_i`=1.
- When `start_i`=0 → DivFree, `ready_o`=0, `result_o`=0.

Rules:
- Operand changes after acceptance are ignored.
- `annul_i` has priority over `start_i` in every state.
- Signed 0x80000000 / 0xFFFFFFFF produces quotient 0x80000000 and remainder 0; no trap is raised.

## Timing
- Reset (asynchronous, `rst`=0): state DivFree, `cnt`=0, `dividend`=0, `ready_o`=0, `result_o`=0. Reset during DivOn aborts immediately.
- Latency, nonzero divisor: E0 accepts the request; E1–E32 perform the 32 steps; E33 finalizes. `ready_o` is high after E33, i.e. 34 edges after the start was first sampled.
- Latency, divide by zero: `ready_o` is high after E1, i.e. 2 edges.
- `ready_o` and `result_o` are registered; there is no combinational path from inputs to outputs.
- EX must drop `start_i` in the cycle after it sees `ready_o`. A new request is accepted no earlier than one cycle after that, from DivFree.
- `annul_i` and `start_i` asserted together in DivFree: the request is not accepted.

## Structure
- Shared defines file gains:
  - State encodings DivFree=2'b00, DivByZero=2'b01, DivOn=2'b10, DivEnd=2'b11.
  - DivResultReady/NotReady, DivStart/Stop.
  - `EXE_DIV_OP` and `EXE_DIVU_OP`.
- Single module; no sub-module. The 33-bit subtractor is inline.
- EX adds:
  - outputs `div_opdata1_o`, `div_opdata2_o`, `div_start_o`, `signed_div_o`, `stallreq_o`;
  - inputs `div_result_i` and `div_ready_i`.

## Test plan
- Unsigned 100 / 7, `start_i` held → `ready_o` rises 34 edges after E0; `result_o` = {32'd2, 32'd14}. Dropping `start_i` returns to DivFree next edge with `result_o`=0.
- Signed −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / −2 → quotient 0xFFFFFFFD, remainder 1.
- 5 / 0, either mode → `ready_o` after 2 edges with `result_o`=0.
- Start 0xFFFFFFFF / 0x10 unsigned; pulse `annul_i` at `cnt`=10 → DivFree, `ready_o` never asserts. Restart the same operands → quotient 0x0FFFFFFF, remainder 0xF.
- Assert `rst`=0 mid-DivOn → outputs zero immediately. After release, signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Change `opdata1_i`/`opdata2_i` every cycle during DivOn → result matches the operands latched at E0.
